// File: rtl/prio_enc_pipe_pkg.sv
// Shared constants and helpers for the pipelined priority encoder.
package prio_enc_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Index width never drops below one bit, even for degenerate widths.
  function automatic int idx_w(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_enc_pipe_if.sv
// Streaming request/result bundle: the master drives requests and consumes results.
interface prio_enc_pipe_if
  import prio_enc_pkg::*;
#(
  parameter int N = 8
) ();

  localparam int IDX_W = idx_w(N);

  logic [N-1:0]     in_vec;
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_none;
  logic             out_multi;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_vec, in_valid, out_ready,
    input  in_ready, out_idx, out_none, out_multi, out_valid
  );

  modport slave (
    input  in_vec, in_valid, out_ready,
    output in_ready, out_idx, out_none, out_multi, out_valid
  );

endinterface

// File: rtl/prio_enc_pipe_find.sv
// Combinational winner search: highest set bit, or first set bit at/after start (wrapping at N).
module prio_enc_find
  import prio_enc_pkg::*;
#(
  parameter  int N     = 8,
  localparam int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     vec,
  input  logic [IDX_W-1:0] start,
  input  logic             rr,
  output logic [IDX_W-1:0] idx,
  output logic             none,
  output logic             multi
);

  logic [N-1:0]     rotVec;
  logic [IDX_W-1:0] lowIdx;
  logic [IDX_W-1:0] highIdx;
  logic [IDX_W:0]   rrSum;

  // Rotating the doubled vector puts request 'start' at bit 0 without a modulo.
  always_comb begin
    rotVec = N'({vec, vec} >> start);
  end

  always_comb begin
    lowIdx = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rotVec[j]) lowIdx = IDX_W'(j);
    end
  end

  always_comb begin
    highIdx = '0;
    for (int j = 0; j < N; j++) begin
      if (vec[j]) highIdx = IDX_W'(j);
    end
  end

  always_comb begin
    rrSum = {1'b0, lowIdx} + {1'b0, start};
    if (rrSum >= (IDX_W + 1)'(N)) rrSum = rrSum - (IDX_W + 1)'(N);
  end

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign none  = ~|vec;
  assign multi = |(vec & (vec - N'(1)));
  assign idx   = none ? '0 : (rr ? IDX_W'(rrSum) : highIdx);

endmodule

// File: rtl/prio_enc_pipe.sv
// Registered priority encoder with a one-deep output stage and valid/ready on both sides.
module prio_enc_pipe
  import prio_enc_pkg::*;
#(
  parameter int N    = 8,
  parameter int MODE = MODE_FIXED
) (
  input logic             clk,
  input logic             rst,
  prio_enc_pipe_if.slave  io
);

  localparam int   IDX_W = idx_w(N);
  localparam logic IS_RR = (MODE == MODE_RR);

  logic [IDX_W-1:0] findIdx;
  logic             findNone;
  logic             findMulti;

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             none_q, none_d;
  logic             multi_q, multi_d;
  logic             valid_q, valid_d;
  logic             inReady;
  logic             accept;

  prio_enc_find #(.N(N)) u_find (
    .vec   (io.in_vec),
    .start (ptr_q),
    .rr    (IS_RR),
    .idx   (findIdx),
    .none  (findNone),
    .multi (findMulti)
  );

  assign inReady = !valid_q || io.out_ready;
  assign accept  = io.in_valid && inReady;

  // A new accept always wins over a drain, so back-to-back transfers never bubble.
  always_comb begin
    idx_d   = idx_q;
    none_d  = none_q;
    multi_d = multi_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (accept) begin
      idx_d   = findIdx;
      none_d  = findNone;
      multi_d = findMulti;
      valid_d = 1'b1;
      if (IS_RR && !findNone) begin
        ptr_d = (findIdx == IDX_W'(N - 1)) ? '0 : findIdx + IDX_W'(1);
      end
    end else if (io.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      none_q  <= 1'b0;
      multi_q <= 1'b0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      idx_q   <= idx_d;
      none_q  <= none_d;
      multi_q <= multi_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign io.in_ready  = inReady;
  assign io.out_idx   = idx_q;
  assign io.out_none  = none_q;
  assign io.out_multi = multi_q;
  assign io.out_valid = valid_q;

endmodule

// File: tb/tb_prio_enc_pipe.sv
// Bench for prio_enc_pipe: fixed and round-robin at N=8, round-robin at N=5.
module tb_prio_enc_pipe;
  import prio_enc_pkg::*;

  typedef struct {
    int idx;
    bit none;
    bit multi;
  } result_t;

  typedef struct {
    bit         resetFirst;
    bit         useRr;
    logic [7:0] vec;
    int         idx;
    bit         none;
    bit         multi;
  } vector_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] vec8;
  logic       valid8, ready8;
  logic [4:0] vec5;
  logic       valid5, ready5;

  int checksTotal  = 0;
  int checksPassed = 0;

  vector_t vectors[$];
  result_t qFix[$];
  result_t qRr[$];
  result_t qSmall[$];
  int      ptrRr, ptrSmall;

  always #5 clk = ~clk;

  prio_enc_pipe_if #(.N(8)) ifFix ();
  prio_enc_pipe_if #(.N(8)) ifRr ();
  prio_enc_pipe_if #(.N(5)) ifSmall ();

  // Both N=8 instances share one stimulus stream; their handshakes behave identically.
  assign ifFix.in_vec     = vec8;
  assign ifFix.in_valid   = valid8;
  assign ifFix.out_ready  = ready8;
  assign ifRr.in_vec      = vec8;
  assign ifRr.in_valid    = valid8;
  assign ifRr.out_ready   = ready8;
  assign ifSmall.in_vec   = vec5;
  assign ifSmall.in_valid = valid5;
  assign ifSmall.out_ready = ready5;

  prio_enc_pipe #(.N(8), .MODE(MODE_FIXED)) dutFix (.clk(clk), .rst(rst), .io(ifFix));
  prio_enc_pipe #(.N(8), .MODE(MODE_RR))    dutRr (.clk(clk), .rst(rst), .io(ifRr));
  prio_enc_pipe #(.N(5), .MODE(MODE_RR))    dutSmall (.clk(clk), .rst(rst), .io(ifSmall));

  // Reference: scan the request bits directly, counting ones for the multi flag.
  function automatic result_t refModel(input int v, input int n, input bit rr, input int ptr);
    result_t r;
    int ones = 0;
    r.idx = 0;
    r.none = (v == 0);
    for (int i = 0; i < n; i++) if (((v >> i) & 1) == 1) ones++;
    r.multi = (ones > 1);
    if (v != 0) begin
      if (!rr) begin
        for (int i = n - 1; i >= 0; i--) if (((v >> i) & 1) == 1) begin r.idx = i; break; end
      end else begin
        for (int k = 0; k < n; k++) begin
          int i = (ptr + k) % n;
          if (((v >> i) & 1) == 1) begin r.idx = i; break; end
        end
      end
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checksTotal++;
    if (actual == expected) checksPassed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    valid8 = 1'b0;
    valid5 = 1'b0;
    ready8 = 1'b1;
    ready5 = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input vector_t v, input int n);
    if (v.resetFirst) doReset();
    vec8 = v.vec;
    valid8 = 1'b1;
    ready8 = 1'b1;
    tick();
    if (v.useRr) begin
      checkOutput($sformatf("rr[%0d] valid", n), ifRr.out_valid, 1);
      checkOutput($sformatf("rr[%0d] idx", n), ifRr.out_idx, v.idx);
      checkOutput($sformatf("rr[%0d] none", n), ifRr.out_none, v.none);
      checkOutput($sformatf("rr[%0d] multi", n), ifRr.out_multi, v.multi);
    end else begin
      checkOutput($sformatf("fix[%0d] valid", n), ifFix.out_valid, 1);
      checkOutput($sformatf("fix[%0d] idx", n), ifFix.out_idx, v.idx);
      checkOutput($sformatf("fix[%0d] none", n), ifFix.out_none, v.none);
      checkOutput($sformatf("fix[%0d] multi", n), ifFix.out_multi, v.multi);
    end
  endtask

  task automatic stepModel(inout result_t q[$], inout int ptr, input int v, input bit valid,
                           input bit ready, input int n, input bit rr);
    result_t r;
    bit acc = valid && (q.size() == 0 || ready);
    if (q.size() != 0 && ready) void'(q.pop_front());
    if (acc) begin
      r = refModel(v, n, rr, ptr);
      q.push_back(r);
      if (rr && !r.none) ptr = (r.idx + 1) % n;
    end
  endtask

  task automatic compareQueue(input string name, input result_t q[$], input int valid,
                              input int idx, input int none, input int multi);
    checkOutput({name, " valid"}, valid, int'(q.size() != 0));
    if (q.size() != 0) begin
      checkOutput({name, " idx"}, idx, q[0].idx);
      checkOutput({name, " none"}, none, q[0].none);
      checkOutput({name, " multi"}, multi, q[0].multi);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec8 = '0;
    vec5 = '0;
    doReset();
    checkOutput("reset valid", ifFix.out_valid, 0);
    checkOutput("reset idx", ifFix.out_idx, 0);
    checkOutput("reset none", ifFix.out_none, 0);
    checkOutput("reset multi", ifFix.out_multi, 0);
    checkOutput("reset in_ready", ifFix.in_ready, 1);

    for (int i = 0; i < 8; i++) begin
      vector_t v;
      v = '{1'b0, 1'b0, 8'(1 << i), i, 1'b0, 1'b0};
      vectors.push_back(v);
    end
    vectors.push_back('{1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0});
    vectors.push_back('{1'b0, 1'b0, 8'b0110_0101, 6, 1'b0, 1'b1});
    vectors.push_back('{1'b0, 1'b0, 8'h80, 7, 1'b0, 1'b0});
    vectors.push_back('{1'b1, 1'b1, 8'b1000_0101, 0, 1'b0, 1'b1});
    vectors.push_back('{1'b0, 1'b1, 8'b1000_0101, 2, 1'b0, 1'b1});
    vectors.push_back('{1'b0, 1'b1, 8'b1000_0101, 7, 1'b0, 1'b1});
    vectors.push_back('{1'b0, 1'b1, 8'b1000_0101, 0, 1'b0, 1'b1});
    foreach (vectors[k]) applyStimulus(vectors[k], k);
    valid8 = 1'b0;
    tick();
    checkOutput("drain valid", ifFix.out_valid, 0);

    // Backpressure: outputs freeze, then a simultaneous drain/accept keeps flowing.
    doReset();
    vec8 = 8'h10; valid8 = 1'b1; ready8 = 1'b0;
    tick();
    checkOutput("bp first idx", ifFix.out_idx, 4);
    checkOutput("bp in_ready low", ifFix.in_ready, 0);
    vec8 = 8'h02;
    tick();
    checkOutput("bp hold valid", ifFix.out_valid, 1);
    checkOutput("bp hold idx", ifFix.out_idx, 4);
    checkOutput("bp hold in_ready", ifFix.in_ready, 0);
    ready8 = 1'b1;
    #1;
    checkOutput("bp in_ready high", ifFix.in_ready, 1);
    tick();
    checkOutput("bp b2b valid", ifFix.out_valid, 1);
    checkOutput("bp b2b idx", ifFix.out_idx, 1);
    vec8 = 8'h08;
    tick();
    checkOutput("bp b2b2 idx", ifFix.out_idx, 3);
    valid8 = 1'b0;
    tick();
    checkOutput("bp drained", ifFix.out_valid, 0);

    // Reset mid-handshake with the round-robin pointer parked at 5.
    doReset();
    vec8 = 8'h10; valid8 = 1'b1; ready8 = 1'b0;
    tick();
    checkOutput("rst pre idx", ifRr.out_idx, 4);
    rst = 1'b1; vec8 = 8'hFF; ready8 = 1'b1;
    tick();
    checkOutput("rst valid", ifRr.out_valid, 0);
    checkOutput("rst idx", ifRr.out_idx, 0);
    rst = 1'b0;
    tick();
    checkOutput("rst ptr idx", ifRr.out_idx, 0);
    checkOutput("rst ptr multi", ifRr.out_multi, 1);
    valid8 = 1'b0;

    // N=5 wrap: pointer must return to 0 after winner 4, not advance to 5.
    doReset();
    vec5 = 5'b10000; valid5 = 1'b1;
    tick();
    checkOutput("n5 idx4", ifSmall.out_idx, 4);
    vec5 = 5'b00011;
    tick();
    checkOutput("n5 wrap idx", ifSmall.out_idx, 0);
    vec5 = 5'b00001;
    tick();
    checkOutput("n5 idx0", ifSmall.out_idx, 0);
    checkOutput("n5 multi", ifSmall.out_multi, 0);
    valid5 = 1'b0;

    doReset();
    ptrRr = 0;
    ptrSmall = 0;
    for (int c = 0; c < 400; c++) begin
      int dummyPtr = 0;
      vec8 = 8'($urandom);
      if ($urandom_range(0, 7) == 0) vec8 = '0;
      valid8 = ($urandom_range(0, 3) != 0);
      ready8 = ($urandom_range(0, 2) != 0);
      vec5 = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) vec5 = '0;
      valid5 = ($urandom_range(0, 3) != 0);
      ready5 = ($urandom_range(0, 2) != 0);
      #1;
      checkOutput("rand fix in_ready", ifFix.in_ready, int'(qFix.size() == 0 || ready8));
      checkOutput("rand rr in_ready", ifRr.in_ready, int'(qRr.size() == 0 || ready8));
      checkOutput("rand n5 in_ready", ifSmall.in_ready, int'(qSmall.size() == 0 || ready5));
      stepModel(qFix, dummyPtr, int'(vec8), valid8, ready8, 8, 1'b0);
      stepModel(qRr, ptrRr, int'(vec8), valid8, ready8, 8, 1'b1);
      stepModel(qSmall, ptrSmall, int'(vec5), valid5, ready5, 5, 1'b1);
      tick();
      compareQueue("rand fix", qFix, ifFix.out_valid, ifFix.out_idx, ifFix.out_none, ifFix.out_multi);
      compareQueue("rand rr", qRr, ifRr.out_valid, ifRr.out_idx, ifRr.out_none, ifRr.out_multi);
      compareQueue("rand n5", qSmall, ifSmall.out_valid, ifSmall.out_idx, ifSmall.out_none,
                   ifSmall.out_multi);
    end

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
